// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared constants, FSM state type and byte helpers for the commit tracer
package trace_pkg;

    localparam logic [31:0] UART_ADDR = 32'h0003_0000;

    typedef enum logic [1:0] {IDLE, HOLD, SEND, RESTORE} state_e;

    function automatic logic [7:0] hex_char(input logic [3:0] nibble);
        return (nibble < 4'd10) ? (8'h30 + {4'h0, nibble}) : (8'h57 + {4'h0, nibble});
    endfunction

    // Bytes emitted per record, including the optional sequence prefix.
    function automatic int unsigned rec_bytes(input int unsigned rec_w, input bit hex, input bit seq);
        int unsigned b;
        b = hex ? (rec_w / 4 + 1) : (rec_w / 8);
        if (seq) b = b + (hex ? 9 : 4);
        return b;
    endfunction

endpackage

// File: rtl/commit_trace_bridge_if.sv
// rtl/commit_trace_bridge_if.sv - commit stream, core-side bus and memory-side bus bundle
interface commit_trace_bridge_if #(parameter int RECORD_W = 72);

    logic                commit_valid;
    logic [RECORD_W-1:0] commit_data;
    logic                commit_ready;
    logic                flush;
    logic                cpu_rdy;
    logic [7:0]          cpu_mem_dout;
    logic [31:0]         cpu_mem_a;
    logic                cpu_mem_wr;
    logic [7:0]          cpu_mem_din;
    logic [7:0]          mem_din;
    logic [7:0]          mem_dout;
    logic [31:0]         mem_a;
    logic                mem_wr;
    logic                io_buffer_full;

    modport slave (
        input  commit_valid, commit_data, flush, cpu_mem_dout, cpu_mem_a, cpu_mem_wr,
               mem_din, io_buffer_full,
        output commit_ready, cpu_rdy, cpu_mem_din, mem_dout, mem_a, mem_wr
    );

    modport master (
        output commit_valid, commit_data, flush, cpu_mem_dout, cpu_mem_a, cpu_mem_wr,
               mem_din, io_buffer_full,
        input  commit_ready, cpu_rdy, cpu_mem_din, mem_dout, mem_a, mem_wr
    );

endinterface

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - synchronous FIFO with occupancy count; rdy low freezes it
module trace_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rdy,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = rdy & push & ~full;
    assign do_pop  = rdy & pop & ~empty;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (do_push && !do_pop)      count_d = count_q + CW'(1);
        else if (!do_push && do_pop) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/commit_trace_bridge.sv
// rtl/commit_trace_bridge.sv - buffers commit records and bursts them to the UART over the shared bus
// TRACE_SEQ_EN: prefix each record with a 32-bit push sequence number
module commit_trace_bridge
    import trace_pkg::*;
#(
    parameter int RECORD_W     = 72,
    parameter int DEPTH        = 8,
    parameter int DRAIN_THRESH = 4,
    parameter int HEX_MODE     = 0
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 rdy_in,
    commit_trace_bridge_if.slave bus
);
`ifdef TRACE_SEQ_EN
    localparam bit SEQ_EN = 1'b1;
`else
    localparam bit SEQ_EN = 1'b0;
`endif
    localparam int NIB   = RECORD_W / 4;
    localparam int PRE   = SEQ_EN ? ((HEX_MODE != 0) ? 9 : 4) : 0;
    localparam int B     = int'(rec_bytes(RECORD_W, HEX_MODE != 0, SEQ_EN));
    localparam int IDX_W = $clog2(B + 1);
    localparam int W     = RECORD_W + (SEQ_EN ? 32 : 0);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [7:0]        save_q, save_d;
    logic              restore_q, restore_d;
    logic              push, pop, full, empty, last_byte;
    logic [CNT_W-1:0]  count;
    logic [W-1:0]      wdata, rdata;
    logic [RECORD_W-1:0] rec;
    logic [31:0]       seq;
    logic [7:0]        tx_byte;

    assign push              = bus.commit_valid & ~full;
    assign bus.commit_ready  = ~full;
    assign rec               = rdata[RECORD_W-1:0];
    assign last_byte         = (idx_q == IDX_W'(B - 1));

`ifdef TRACE_SEQ_EN
    logic [31:0] seq_q, seq_d;

    always_comb begin
        seq_d = seq_q;
        if (push) seq_d = seq_q + 32'd1;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in)   seq_q <= '0;
        else if (rdy_in) seq_q <= seq_d;
    end

    assign wdata = {seq_q, bus.commit_data};
    assign seq   = rdata[W-1 -: 32];
`else
    assign wdata = bus.commit_data;
    assign seq   = '0;
`endif

    trace_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .rdy   (rdy_in),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Byte idx of the head record: optional sequence prefix, then the record body.
    always_comb begin
        int i;
        i       = {{(32 - IDX_W){1'b0}}, idx_q};
        tx_byte = 8'h00;
        if (HEX_MODE == 0) begin
            if (i < PRE) tx_byte = 8'(seq >> (8 * i));
            else         tx_byte = 8'(rec >> (8 * (i - PRE)));
        end else begin
            if (i < PRE - 1)       tx_byte = hex_char(4'(seq >> (4 * (7 - i))));
            else if (i == PRE - 1) tx_byte = 8'h20;
            else if (i < PRE + NIB) tx_byte = hex_char(4'(rec >> (4 * (NIB - 1 - (i - PRE)))));
            else                   tx_byte = 8'h0a;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            save_q    <= '0;
            restore_q <= 1'b0;
        end else if (rdy_in) begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            save_q    <= save_d;
            restore_q <= restore_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        save_d    = save_q;
        restore_d = restore_q;
        case (state_q)
            IDLE: begin
                restore_d = 1'b0;
                if (count >= CNT_W'(DRAIN_THRESH) || full || (bus.flush && !empty))
                    state_d = HOLD;
            end
            HOLD: begin
                save_d  = bus.mem_din;
                state_d = SEND;
            end
            SEND: begin
                if (!bus.io_buffer_full) begin
                    if (last_byte) begin
                        idx_d = '0;
                        // A concurrent push keeps the burst going.
                        if (count == CNT_W'(1) && !push) state_d = RESTORE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            RESTORE: begin
                restore_d = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.cpu_rdy     = rdy_in & (state_q == IDLE);
        bus.cpu_mem_din = bus.mem_din;
        bus.mem_a       = '0;
        bus.mem_dout    = '0;
        bus.mem_wr      = 1'b0;
        pop             = 1'b0;
        case (state_q)
            IDLE: begin
                bus.mem_a    = bus.cpu_mem_a;
                bus.mem_dout = bus.cpu_mem_dout;
                bus.mem_wr   = bus.cpu_mem_wr;
                if (restore_q) bus.cpu_mem_din = save_q;
            end
            SEND: begin
                if (!bus.io_buffer_full) begin
                    bus.mem_a    = UART_ADDR;
                    bus.mem_wr   = 1'b1;
                    bus.mem_dout = tx_byte;
                    pop          = last_byte;
                end
            end
            default: ;
        endcase
    end

endmodule
